sinerom_arbiter: RTL and testbench

//  Shares one synchronous-read sine ROM (1-cycle registered read) between two requesters,
//  e.g. sine and cosine phase generators. Round-robin arbitration, one grant per cycle,

---
 rtl/sig_gen_pkg.sv | 14 +
 rtl/rr_arb2.sv | 36 +++
 rtl/sinerom_arbiter.sv | 78 +++++++
 tb/tb_sinerom_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sig_gen_pkg.sv
// rtl/sig_gen_pkg.sv - channel and read-tag types shared by the sine/cosine generator blocks
package sig_gen_pkg;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_t;

    typedef struct packed {
        logic  vld;
        chan_t ch;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, one grant per cycle
module rr_arb2
    import sig_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    chan_t last_grant;

    // Reset to CH1 so that ch0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= CH1;
        end else if (gnt[0]) begin
            last_grant <= CH0;
        end else if (gnt[1]) begin
            last_grant <= CH1;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == CH1) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/sinerom_arbiter.sv
// rtl/sinerom_arbiter.sv - shares one registered-read sine ROM between two requesters
module sinerom_arbiter
    import sig_gen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    output logic                     gnt0,
    output logic                     rvalid0,
    output logic [DATA_WIDTH-1:0]    rdata0,
    input  logic                     req1,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    output logic                     gnt1,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_dout
);

    logic [1:0]               gnt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    rd_tag_t                  tag_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1, req0}),
        .gnt   (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Without a grant the ROM keeps seeing the last issued address; its output is ignored.
    always_comb begin
        rom_addr = addr_q;
        if (gnt[0]) begin
            rom_addr = addr0;
        end else if (gnt[1]) begin
            rom_addr = addr1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            tag_q  <= '{vld: 1'b0, ch: CH0};
        end else begin
            addr_q    <= rom_addr;
            tag_q.vld <= |gnt;
            tag_q.ch  <= gnt[1] ? CH1 : CH0;
        end
    end

    // rom_dout is valid the cycle after the tag was captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= tag_q.vld && (tag_q.ch == CH0);
            rvalid1 <= tag_q.vld && (tag_q.ch == CH1);
            if (tag_q.vld && (tag_q.ch == CH0)) begin
                rdata0 <= rom_dout;
            end
            if (tag_q.vld && (tag_q.ch == CH1)) begin
                rdata1 <= rom_dout;
            end
        end
    end

endmodule

// File: tb/tb_sinerom_arbiter.sv
// tb/tb_sinerom_arbiter.sv - scoreboard bench for sinerom_arbiter with an addr-valued ROM model
module tb_sinerom_arbiter;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] addr0, addr1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1, rom_addr, rom_dout;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    int         m_last = 1;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] e0 = 8'h00;
    logic [7:0] e1 = 8'h00;

    sinerom_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .addr0    (addr0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .req1     (req1),
        .addr1    (addr1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    // ROM contents mem[a] = a, one-cycle registered read.
    always @(posedge clk) rom_dout <= rom_addr;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: expected grant, address and future responses.
    always @(negedge clk) begin
        logic [1:0] eg;
        logic [7:0] ea;
        eg = 2'b00;
        if (rst_n) begin
            if (req0 && req1) eg = (m_last == 1) ? 2'b01 : 2'b10;
            else              eg = {req1, req0};
        end
        chk("gnt0", {31'b0, gnt0}, {31'b0, eg[0]});
        chk("gnt1", {31'b0, gnt1}, {31'b0, eg[1]});
        if (rst_n) begin
            ea = eg[0] ? addr0 : (eg[1] ? addr1 : m_addr);
            chk("rom_addr", {24'b0, rom_addr}, {24'b0, ea});
        end
        if (eg[0]) begin
            q0.push_back('{due: cyc + 2, data: addr0});
            m_last = 0;
            m_addr = addr0;
        end
        if (eg[1]) begin
            q1.push_back('{due: cyc + 2, data: addr1});
            m_last = 1;
            m_addr = addr1;
        end
        if (!rst_n) begin
            m_last = 1;
            m_addr = 8'h00;
            while (q0.size() > 0 && q0[$].due > cyc) void'(q0.pop_back());
            while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (rvalid0) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin
                chk("rdata0", {24'b0, rdata0}, {24'b0, q0[0].data});
                e0 = q0[0].data;
                void'(q0.pop_front());
            end else begin
                chk("rvalid0_spurious", 32'd1, 32'd0);
            end
        end else if (q0.size() > 0 && q0[0].due == cyc) begin
            chk("rvalid0_missing", 32'd0, 32'd1);
            void'(q0.pop_front());
        end else begin
            chk("rdata0_hold", {24'b0, rdata0}, {24'b0, e0});
        end
        if (rvalid1) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                chk("rdata1", {24'b0, rdata1}, {24'b0, q1[0].data});
                e1 = q1[0].data;
                void'(q1.pop_front());
            end else begin
                chk("rvalid1_spurious", 32'd1, 32'd0);
            end
        end else if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("rvalid1_missing", 32'd0, 32'd1);
            void'(q1.pop_front());
        end else begin
            chk("rdata1_hold", {24'b0, rdata1}, {24'b0, e1});
        end
        if (!rst_n) begin
            e0 = 8'h00;
            e1 = 8'h00;
        end
    end

    task automatic tick(input logic rn, input logic r0, input logic [7:0] a0,
                        input logic r1, input logic [7:0] a1);
        rst_n = rn;
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both requesting: no grants, no responses.
        repeat (3) tick(1'b0, 1'b1, 8'h11, 1'b1, 8'h22);
        // Single ch0 read, then idle so rdata0 is seen holding.
        tick(1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
        repeat (4) tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        // Contention straight after reset.
        repeat (2) tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (4) tick(1'b1, 1'b1, 8'h10, 1'b1, 8'h20);
        // Back-to-back ch1 reads.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'h00, 1'b1, 8'(i));
        repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        // Reset while a ch0 read is in flight, then contention.
        tick(1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) tick(1'b1, 1'b1, 8'h33, 1'b1, 8'h44);
        // Idle hold of the last issued address.
        tick(1'b1, 1'b1, 8'h7F, 1'b0, 8'h00);
        repeat (5) tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom % 64) != 0, 1'($urandom), 8'($urandom),
                 1'($urandom), 8'($urandom));
        end
        repeat (4) tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("queues_drained", q0.size() + q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
